// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings for the slave-side mux and its default slave:
//   - HTRANS transfer-type codes
//   - HRESP response codes
//   - default number of decoded slave ports
//   - default-slave FSM state type
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int AHB_NUM_SLAVES = 4;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // An address phase only asks for a response when it carries a real transfer.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ----------------------------------------------------------------------------
// ahb_default_slave
// Answers data phases that no real slave owns. Idle/busy transfers get a
// zero-wait OKAY; active transfers get the two-cycle AHB ERROR response.
// Counts ERROR responses in a saturating 8-bit counter.
// Ports:
//   HCLK       in   bus clock
//   HRESET     in   synchronous active-high reset
//   hready     in   muxed HREADY (address phase sampled when 1)
//   err_req    in   sampled address phase is default-owned and active
//   ds_hready  out  default-slave ready
//   ds_hresp   out  default-slave response
//   err_cnt    out  saturating count of ERROR responses
// ----------------------------------------------------------------------------
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       hready,
    input  logic       err_req,
    output logic       ds_hready,
    output logic       ds_hresp,
    output logic [7:0] err_cnt
);

    ds_state_e state, state_nxt;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= DS_IDLE;
            err_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            // ERR1 always moves to ERR2 outside reset, so counting here
            // counts exactly the ERR1->ERR2 transitions.
            if (state == DS_ERR1 && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        ds_hready = 1'b1;
        ds_hresp  = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (hready && err_req)
                    state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = HRESP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                ds_hresp  = HRESP_ERROR;
                // Next address phase is sampled now; back-to-back errors allowed.
                state_nxt = (hready && err_req) ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// ahb_slave_mux
// Slave-to-manager response mux for an AHB-Lite bus. Registers the
// data-phase owner from the address-phase decode and routes that owner's
// HRDATA/HREADYOUT/HRESP back to the manager. Decode misses, multi-hot
// selects and empty selects go to an internal default slave.
// Ports:
//   HCLK         in   bus clock
//   HRESET       in   synchronous active-high reset
//   HSELx        in   [NUM_SLAVES] address-phase slave selects
//   HERROR       in   address-phase decode-miss flag
//   HTRANS       in   [2] address-phase transfer type
//   HRDATA_S     in   [NUM_SLAVES*DATA_W] per-slave read data
//   HREADYOUT_S  in   [NUM_SLAVES] per-slave ready
//   HRESP_S      in   [NUM_SLAVES] per-slave response
//   HRDATA       out  [DATA_W] muxed read data
//   HREADY       out  muxed ready (also fed back to the slaves)
//   HRESP        out  muxed response
//   ERR_CNT      out  [8] saturating count of default-slave ERROR responses
// ----------------------------------------------------------------------------
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = AHB_NUM_SLAVES,
    parameter int DATA_W     = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [NUM_SLAVES-1:0]        HSELx,
    input  logic                         HERROR,
    input  logic [1:0]                   HTRANS,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [7:0]                   ERR_CNT
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic             addr_def;
    logic [IDX_W-1:0] addr_idx;
    logic             sel_seen;
    logic             sel_multi;
    logic             dsel_def;
    logic [IDX_W-1:0] dsel_idx;
    logic             ds_hready;
    logic             ds_hresp;
    logic [DATA_W-1:0] rdata_arr [NUM_SLAVES];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slice
        assign rdata_arr[g] = HRDATA_S[g*DATA_W +: DATA_W];
    end

    // Owner decode: exactly one select with no decode miss picks a real
    // slave; anything else belongs to the default slave.
    always_comb begin
        addr_idx  = '0;
        sel_seen  = 1'b0;
        sel_multi = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (HSELx[i]) begin
                sel_multi = sel_multi | sel_seen;
                sel_seen  = 1'b1;
                addr_idx  = IDX_W'(i);
            end
        end
        addr_def = HERROR | ~sel_seen | sel_multi;
    end

    // Data-phase owner; holds while the current owner stretches the phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_def <= 1'b1;
            dsel_idx <= '0;
        end else if (HREADY) begin
            dsel_def <= addr_def;
            dsel_idx <= addr_idx;
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .hready    (HREADY),
        .err_req   (addr_def & htrans_active(HTRANS)),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp),
        .err_cnt   (ERR_CNT)
    );

    always_comb begin
        if (dsel_def) begin
            HRDATA = '0;
            HREADY = ds_hready;
            HRESP  = ds_hresp;
        end else begin
            HRDATA = rdata_arr[dsel_idx];
            HREADY = HREADYOUT_S[dsel_idx];
            HRESP  = HRESP_S[dsel_idx];
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_mux
// Directed bench for ahb_slave_mux with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_ahb_slave_mux;
    import ahb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'hCAFE_0001;
    localparam logic [31:0] D2 = 32'h2222_0002;
    localparam logic [31:0] D3 = 32'h3333_0003;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic [NS-1:0]      HSELx;
    logic               HERROR;
    logic [1:0]         HTRANS;
    logic [NS*DW-1:0]   HRDATA_S;
    logic [NS-1:0]      HREADYOUT_S;
    logic [NS-1:0]      HRESP_S;
    logic [DW-1:0]      HRDATA;
    logic               HREADY;
    logic               HRESP;
    logic [7:0]         ERR_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_slave_mux #(.NUM_SLAVES(NS), .DATA_W(DW)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSELx       (HSELx),
        .HERROR      (HERROR),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .ERR_CNT     (ERR_CNT)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic [NS-1:0] sel, input logic err, input logic [1:0] trans);
        HSELx  = sel;
        HERROR = err;
        HTRANS = trans;
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic resp, input logic [7:0] cnt);
        chk({tag, ".hready"}, {31'd0, HREADY}, {31'd0, rdy});
        chk({tag, ".hresp"},  {31'd0, HRESP},  {31'd0, resp});
        chk({tag, ".errcnt"}, {24'd0, ERR_CNT}, {24'd0, cnt});
    endtask

    initial begin
        HRESET      = 1'b1;
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        HRDATA_S    = {D3, D2, D1, D0};
        HREADYOUT_S = 4'hF;
        HRESP_S     = 4'h0;

        // Reset state
        tick();
        tick();
        chk_out("reset", 1'b1, 1'b0, 8'd0);
        chk("reset.hrdata", HRDATA, 32'd0);
        HRESET = 1'b0;

        // Slave 1 read
        addr(4'b0010, 1'b0, HTRANS_NONSEQ);
        tick();
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        chk("s1.hrdata", HRDATA, D1);
        chk_out("s1", 1'b1, 1'b0, 8'd0);
        HRESP_S[1] = 1'b1;
        #1;
        chk("s1.resp_pass", {31'd0, HRESP}, 32'd1);
        HRESP_S[1] = 1'b0;
        tick();
        chk("idle.hrdata", HRDATA, 32'd0);
        chk_out("idle", 1'b1, 1'b0, 8'd0);

        // Decode miss, NONSEQ
        addr(4'b0000, 1'b1, HTRANS_NONSEQ);
        tick();
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        chk_out("miss.err1", 1'b0, 1'b1, 8'd0);
        tick();
        chk_out("miss.err2", 1'b1, 1'b1, 8'd1);
        tick();
        chk_out("miss.idle", 1'b1, 1'b0, 8'd1);

        // Multi-hot select, SEQ
        addr(4'b0101, 1'b0, HTRANS_SEQ);
        tick();
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        chk_out("multi.err1", 1'b0, 1'b1, 8'd1);
        tick();
        chk_out("multi.err2", 1'b1, 1'b1, 8'd2);
        tick();

        // Decode miss with IDLE and BUSY: zero-wait OKAY, no count
        addr(4'b0000, 1'b1, HTRANS_IDLE);
        tick();
        chk_out("miss_idle", 1'b1, 1'b0, 8'd2);
        addr(4'b0000, 1'b1, HTRANS_BUSY);
        tick();
        chk_out("miss_busy", 1'b1, 1'b0, 8'd2);

        // Slave 2 stalls while the next address phase targets slave 0
        addr(4'b0100, 1'b0, HTRANS_NONSEQ);
        tick();
        HREADYOUT_S[2] = 1'b0;
        addr(4'b0001, 1'b0, HTRANS_NONSEQ);
        #1;
        chk("stall.c1.hready", {31'd0, HREADY}, 32'd0);
        chk("stall.c1.hrdata", HRDATA, D2);
        tick();
        chk("stall.c2.hready", {31'd0, HREADY}, 32'd0);
        chk("stall.c2.hrdata", HRDATA, D2);
        tick();
        chk("stall.c3.hready", {31'd0, HREADY}, 32'd0);
        chk("stall.c3.hrdata", HRDATA, D2);
        HREADYOUT_S[2] = 1'b1;
        #1;
        chk("stall.release", {31'd0, HREADY}, 32'd1);
        tick();
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        chk("s0.hrdata", HRDATA, D0);
        chk_out("s0", 1'b1, 1'b0, 8'd2);
        tick();

        // Back-to-back decode misses
        addr(4'b0000, 1'b1, HTRANS_NONSEQ);
        tick();
        chk_out("b2b.err1a", 1'b0, 1'b1, 8'd2);
        tick();
        chk_out("b2b.err2a", 1'b1, 1'b1, 8'd3);
        tick();
        chk_out("b2b.err1b", 1'b0, 1'b1, 8'd3);
        tick();
        chk_out("b2b.err2b", 1'b1, 1'b1, 8'd4);

        // 300 more misses: counter saturates
        for (int i = 0; i < 600; i++) tick();
        chk_out("sat", 1'b1, 1'b1, 8'd255);
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        tick();
        chk_out("sat.idle", 1'b1, 1'b0, 8'd255);

        // Reset during ERR1 aborts the response
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk_out("rst2", 1'b1, 1'b0, 8'd0);
        addr(4'b0000, 1'b1, HTRANS_NONSEQ);
        tick();
        chk_out("rst_err1", 1'b0, 1'b1, 8'd0);
        HRESET = 1'b1;
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        tick();
        HRESET = 1'b0;
        chk_out("rst_abort", 1'b1, 1'b0, 8'd0);
        chk("rst_abort.hrdata", HRDATA, 32'd0);
        tick();
        chk_out("rst_after", 1'b1, 1'b0, 8'd0);

        // Normal error after the abort counts once
        addr(4'b0000, 1'b1, HTRANS_SEQ);
        tick();
        addr(4'b0000, 1'b0, HTRANS_IDLE);
        chk_out("post.err1", 1'b0, 1'b1, 8'd0);
        tick();
        chk_out("post.err2", 1'b1, 1'b1, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
